bus_port_fifo: RTL
==================

# bus_port_fifo

Per-device port that sits between one device and the bus generator/arbiter. It buffers outgoing packets in a TX FIFO and presents them on the bus-side pop interface (pndng/D_pop/pop). It captures packets the bus delivers on push/D_push into an RX FIFO for the device. It filters misrouted deliveries by destination address and counts overflows and misroutes for the checker.

## Interface
Parameters:
- tama_de_paquete, 16: packet width in bits; [tama_de_paquete-1 -: 8] is the destination address.
- tam_fifo, 12: depth of each FIFO, in packets (>=2).
- id, 0: this device's 8-bit address.
- broadcast, 8'hFF: broadcast address, always accepted.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- dev_push  in  1  device writes dev_data into TX FIFO.
- dev_data  in  tama_de_paquete  packet from device.
- tx_full  out  1  TX FIFO holds tam_fifo packets.
- pndng  out  1  TX FIFO non-empty (to bus).
- D_pop  out  tama_de_paquete  TX head packet (to bus).
- pop  in  1  bus consumes TX head.
- push  in  1  bus delivers D_push to this device.
- D_push  in  tama_de_paquete  delivered packet.
- rx_valid  out  1  RX FIFO non-empty.
- rx_data  out  tama_de_paquete  RX head packet.
- rx_pop  in  1  device consumes RX head.
- tx_ovf  out  1  sticky: dev_push while full with no pop.
- rx_ovf  out  1  sticky: accepted push dropped because RX full.
- misroute_cnt  out  8  saturating count of rejected deliveries.

## Operation
- Both FIFOs are circular buffers with read pointer, write pointer and an occupancy counter (0..tam_fifo). Pointers wrap from tam_fifo-1 to 0.
- Both FIFOs are first-word-fall-through. D_pop always equals mem[tx_rd], and rx_data always equals mem[rx_rd]. Head data is undefined-but-stable when the FIFO is empty.
- pndng = (tx_count != 0); tx_full = (tx_count == tam_fifo); rx_valid = (rx_count != 0). All are derived from registered counts.
- TX write: dev_push and not full stores the packet. If full and pop is asserted in the same cycle, the write also succeeds and the count stays unchanged. If full with no pop, the packet is dropped and tx_ovf is set.
- TX read: pop with pndng=1 advances tx_rd. pop with pndng=0 is ignored and changes no state.
- Simultaneous TX write and read when not empty and not full: count unchanged, both pointers advance.
- RX accept: push with D_push[MSB:MSB-7] equal to id or broadcast is accepted. Push with any other address is rejected: nothing is stored, and misroute_cnt increments, saturating at 255.
- An accepted push while RX is full with no rx_pop is dropped and sets rx_ovf. An accepted push while full with rx_pop is stored.
- rx_pop with rx_valid=0 is ignored.
- tx_ovf and rx_ovf are cleared only by reset.

## Timing
- Reset: asserting reset (low) asynchronously clears all pointers, counts, tx_ovf, rx_ovf and misroute_cnt. Memory contents are not cleared.
- Outputs during and after reset: pndng=0, tx_full=0, rx_valid=0, tx_ovf=0, rx_ovf=0, misroute_cnt=0.
- Reset asserted mid-transfer discards all buffered packets. The first push or dev_push after reset deassertion is accepted normally on the next rising edge.
- Write-to-visible latency: a packet written at edge N appears on pndng/D_pop (TX) or rx_valid/rx_data (RX) after edge N, i.e. usable in cycle N+1.
- Pop latency: after a pop at edge N, the next head is on D_pop/rx_data in cycle N+1. pndng/rx_valid fall in cycle N+1 if the popped packet was the last one.
- The bus may assert pop in consecutive cycles; each cycle with pndng=1 consumes exactly one packet.
- There is no combinational path from pop to pndng/D_pop or from push to rx_valid.

## Test plan
- Reset then idle: hold reset low 3 cycles, release -> pndng=0, rx_valid=0, tx_full=0, tx_ovf=0, rx_ovf=0, misroute_cnt=0.
- TX order and fill: dev_push 12 packets 16'h0100..16'h010B -> tx_full=1 after the 12th. A 13th dev_push 16'h01FF -> tx_ovf=1, count stays 12. Then 12 pops -> D_pop sequence 16'h0100..16'h010B, pndng=0 after the last.
- Full with simultaneous push and pop: TX full, dev_push 16'h0122 with pop in the same cycle -> tx_ovf stays 0, tx_full stays 1, 16'h0122 emerges last.
- RX filter (id=3): push 16'h0311, 16'hFF22, 16'h0533 -> rx_data 16'h0311 then 16'hFF22, misroute_cnt=1.
- RX overflow and empty pop: 13 accepted pushes with no rx_pop -> rx_ovf=1, 12 packets retained. Drain all 12, then one extra rx_pop -> ignored, rx_valid=0. Also pop with pndng=0 -> no state change.
- Reset mid-operation: with 5 packets in TX and 4 in RX, pulse reset low between clock edges -> pndng and rx_valid drop immediately (before the next edge). A fresh dev_push 16'h0A0A appears on D_pop one cycle later.

Source files
------------

// File: rtl/bus_port_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_port_fifo
// Brief    : Per-device bus port. Holds a TX FIFO toward the bus and an
//            address-filtered RX FIFO from the bus, with overflow and
//            misroute tracking.
// Revision : 1.0 - initial release
// ============================================================================
module bus_port_fifo #(
    parameter int unsigned tama_de_paquete = 16,
    parameter int unsigned tam_fifo        = 12,
    parameter logic [7:0]  id              = 8'd0,
    parameter logic [7:0]  broadcast       = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dev_push,
    input  logic [tama_de_paquete-1:0] dev_data,
    output logic                       tx_full,
    output logic                       pndng,
    output logic [tama_de_paquete-1:0] D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [tama_de_paquete-1:0] D_push,
    output logic                       rx_valid,
    output logic [tama_de_paquete-1:0] rx_data,
    input  logic                       rx_pop,
    output logic                       tx_ovf,
    output logic                       rx_ovf,
    output logic [7:0]                 misroute_cnt
);

    localparam int unsigned     c_ptr_w    = (tam_fifo > 1) ? $clog2(tam_fifo) : 1;
    localparam int unsigned     c_cnt_w    = $clog2(tam_fifo + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(tam_fifo - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(tam_fifo);

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    logic [tama_de_paquete-1:0] r_tx_mem [tam_fifo];
    logic [tama_de_paquete-1:0] r_rx_mem [tam_fifo];
    logic [c_ptr_w-1:0]         r_tx_rd, r_tx_wr, r_rx_rd, r_rx_wr;
    logic [c_cnt_w-1:0]         r_tx_cnt, r_rx_cnt;
    logic                       r_tx_ovf, r_rx_ovf;
    logic [7:0]                 r_misroute_cnt;

    logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic w_tx_rd, w_tx_wr, w_rx_rd, w_rx_wr;
    logic w_addr_ok, w_accept, w_misroute;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == c_full_cnt);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == c_full_cnt);

    // A full FIFO is never empty, so a pop alongside a full-write always frees a slot.
    assign w_tx_rd = pop && !w_tx_empty;
    assign w_tx_wr = dev_push && (!w_tx_full || pop);

    assign w_addr_ok  = (D_push[tama_de_paquete-1 -: 8] == id) ||
                        (D_push[tama_de_paquete-1 -: 8] == broadcast);
    assign w_accept   = push && w_addr_ok;
    assign w_misroute = push && !w_addr_ok;
    assign w_rx_rd    = rx_pop && !w_rx_empty;
    assign w_rx_wr    = w_accept && (!w_rx_full || rx_pop);

    // Storage is deliberately left out of the reset domain.
    always_ff @(posedge clk) begin
        if (w_tx_wr) r_tx_mem[r_tx_wr] <= dev_data;
        if (w_rx_wr) r_rx_mem[r_rx_wr] <= D_push;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_rd        <= '0;
            r_tx_wr        <= '0;
            r_tx_cnt       <= '0;
            r_rx_rd        <= '0;
            r_rx_wr        <= '0;
            r_rx_cnt       <= '0;
            r_tx_ovf       <= 1'b0;
            r_rx_ovf       <= 1'b0;
            r_misroute_cnt <= '0;
        end else begin
            if (w_tx_rd) r_tx_rd <= next_ptr(r_tx_rd);
            if (w_tx_wr) r_tx_wr <= next_ptr(r_tx_wr);
            unique case ({w_tx_wr, w_tx_rd})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase

            if (w_rx_rd) r_rx_rd <= next_ptr(r_rx_rd);
            if (w_rx_wr) r_rx_wr <= next_ptr(r_rx_wr);
            unique case ({w_rx_wr, w_rx_rd})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase

            if (dev_push && w_tx_full && !pop)    r_tx_ovf <= 1'b1;
            if (w_accept && w_rx_full && !rx_pop) r_rx_ovf <= 1'b1;
            if (w_misroute && (r_misroute_cnt != 8'hFF))
                r_misroute_cnt <= r_misroute_cnt + 8'd1;
        end
    end

    assign pndng        = !w_tx_empty;
    assign tx_full      = w_tx_full;
    assign D_pop        = r_tx_mem[r_tx_rd];
    assign rx_valid     = !w_rx_empty;
    assign rx_data      = r_rx_mem[r_rx_rd];
    assign tx_ovf       = r_tx_ovf;
    assign rx_ovf       = r_rx_ovf;
    assign misroute_cnt = r_misroute_cnt;

endmodule
`default_nettype wire
